// File: rtl/sr_pulse_controller.sv
// rtl/sr_pulse_controller.sv - command sequencer producing exclusive S/R pulses for an SR latch bank
module sr_pulse_controller #(
  parameter int N         = 4,
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 1,
  localparam int IW       = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [IW-1:0] cmd_idx,
  input  logic [N-1:0]  q_in,
  output logic [N-1:0]  s_out,
  output logic [N-1:0]  r_out,
  output logic          done,
  output logic          err
);

  localparam logic [1:0] OP_RESET  = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_TOGGLE = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  localparam int CNT_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, PULSE, GAP, CHECK} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [1:0]    op_q, op_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          exp_q, exp_d;
  logic [N-1:0]  s_d, r_d;
  logic          done_d, err_d, ready_d;
  logic [N-1:0]  cmd_onehot, q_at_cmd, q_at_held;
  logic          exp_new;

  // S goes out only for set or toggle-to-one; every other case drives R, so the pair stays exclusive.
  function automatic logic [2*N-1:0] drive(input logic [1:0] op, input logic [IW-1:0] idx,
                                           input logic e);
    logic [N-1:0] oh;
    oh = {{(N-1){1'b0}}, 1'b1} << idx;
    case (op)
      OP_SET:    drive = {oh, {N{1'b0}}};
      OP_RESET:  drive = {{N{1'b0}}, oh};
      OP_TOGGLE: drive = e ? {oh, {N{1'b0}}} : {{N{1'b0}}, oh};
      default:   drive = {{N{1'b0}}, {N{1'b1}}};
    endcase
  endfunction

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    op_d       = op_q;
    idx_d      = idx_q;
    exp_d      = exp_q;
    s_d        = '0;
    r_d        = '0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    // An index past the bank shifts the one-hot out entirely, which flags it as bad.
    cmd_onehot = {{(N-1){1'b0}}, 1'b1} << cmd_idx;
    q_at_cmd   = q_in >> cmd_idx;
    q_at_held  = q_in >> idx_q;
    exp_new    = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          case (cmd_op)
            OP_SET:    exp_new = 1'b1;
            OP_TOGGLE: exp_new = ~q_at_cmd[0];
            default:   exp_new = 1'b0;
          endcase
          op_d  = cmd_op;
          idx_d = cmd_idx;
          exp_d = exp_new;
          if (cmd_op != OP_CLEAR && cmd_onehot == '0) begin
            state_d = CHECK;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d    = PULSE;
            cnt_d      = CW'(PULSE_CYC - 1);
            {s_d, r_d} = drive(cmd_op, cmd_idx, exp_new);
          end
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          state_d = GAP;
          cnt_d   = CW'(GAP_CYC - 1);
        end else begin
          cnt_d      = cnt - 1'b1;
          {s_d, r_d} = drive(op_q, idx_q, exp_q);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          // Read-back is registered into done/err on the edge that enters CHECK.
          state_d = CHECK;
          done_d  = 1'b1;
          err_d   = (op_q == OP_CLEAR) ? (|q_in) : (q_at_held[0] != exp_q);
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= OP_RESET;
      idx_q     <= '0;
      exp_q     <= 1'b0;
      s_out     <= '0;
      r_out     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      exp_q     <= exp_d;
      s_out     <= s_d;
      r_out     <= r_d;
      done      <= done_d;
      err       <= err_d;
      cmd_ready <= ready_d;
    end
  end

endmodule

// File: tb/tb_sr_pulse_controller.sv
// tb/tb_sr_pulse_controller.sv - self-checking bench for sr_pulse_controller with a NOR latch bank model
module tb_sr_pulse_controller;

  localparam int N = 4;
  localparam int P = 2;
  localparam int G = 1;
  localparam logic [1:0] OP_RESET  = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_TOGGLE = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'b00;
  logic [1:0]   cmd_idx = 2'b00;
  logic [N-1:0] q_in;
  logic [N-1:0] s_out, r_out;
  logic         done, err;

  logic         valid3 = 1'b0;
  logic         ready3;
  logic [1:0]   op3 = 2'b00;
  logic [1:0]   idx3 = 2'b00;
  logic [2:0]   q3 = 3'b000;
  logic [2:0]   s3, r3;
  logic         done3, err3;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_accept = 0;

  bit [N-1:0] lq = '0;
  bit [N-1:0] lqb = '1;
  bit [N-1:0] stuck = '0;
  bit [N-1:0] model_latch = '0;

  sr_pulse_controller #(.N(N), .PULSE_CYC(P), .GAP_CYC(G)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_idx(cmd_idx), .q_in(q_in),
    .s_out(s_out), .r_out(r_out), .done(done), .err(err)
  );

  sr_pulse_controller #(.N(3), .PULSE_CYC(P), .GAP_CYC(G)) dut3 (
    .clk(clk), .rst(rst), .cmd_valid(valid3), .cmd_ready(ready3),
    .cmd_op(op3), .cmd_idx(idx3), .q_in(q3),
    .s_out(s3), .r_out(r3), .done(done3), .err(err3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Cross-coupled NOR pair per bit, iterated until it settles.
  always @(s_out or r_out) begin
    for (int i = 0; i < N; i++) begin
      bit sb, rb;
      sb = (s_out[i] === 1'b1);
      rb = (r_out[i] === 1'b1);
      for (int k = 0; k < 3; k++) begin
        lq[i]  = ~(rb | lqb[i]);
        lqb[i] = ~(sb | lq[i]);
      end
    end
  end
  assign q_in = lq & ~stuck;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic do_cmd(input logic [1:0] op, input int idx, input bit chk_period);
    bit [N-1:0] obs, oh, pat_s, pat_r;
    bit target, exp_err;
    for (int t = 0; t < 20 && cmd_ready !== 1'b1; t++) @(negedge clk);
    check("ready_before_cmd", cmd_ready, 1);
    obs   = model_latch & ~stuck;
    oh    = '0;
    oh[idx] = 1'b1;
    pat_s = '0;
    pat_r = '0;
    target = 1'b0;
    case (op)
      OP_SET:    begin pat_s = oh; target = 1'b1; end
      OP_RESET:  pat_r = oh;
      OP_TOGGLE: begin target = ~obs[idx]; if (target) pat_s = oh; else pat_r = oh; end
      default:   pat_r = '1;
    endcase
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_idx   = idx[1:0];
    if (chk_period) check("cmd_period", cyc - last_accept, P + G + 2);
    last_accept = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    model_latch = (model_latch | pat_s) & ~pat_r;
    obs = model_latch & ~stuck;
    exp_err = (op == OP_CLEAR) ? (|obs) : (obs[idx] != target);
    for (int j = 1; j <= P + G + 2; j++) begin
      check("s_and_r_exclusive", s_out & r_out, 0);
      if (op != OP_CLEAR) check("at_most_one_drive", $countones(s_out | r_out) <= 1, 1);
      if (j <= P) begin
        check("pulse_s", s_out, pat_s);
        check("pulse_r", r_out, pat_r);
        check("pulse_done", done, 0);
        check("pulse_ready", cmd_ready, 0);
      end else if (j <= P + G) begin
        check("gap_s", s_out, 0);
        check("gap_r", r_out, 0);
        check("gap_done", done, 0);
      end else if (j == P + G + 1) begin
        check("check_done", done, 1);
        check("check_err", err, exp_err);
        check("check_ready", cmd_ready, 0);
      end else begin
        check("after_done", done, 0);
        check("after_ready", cmd_ready, 1);
      end
      if (j < P + G + 2) @(negedge clk);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset for two cycles, then the idle state must be clean.
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_s", s_out, 0);
    check("rst_r", r_out, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ready", cmd_ready, 1);

    do_cmd(OP_SET, 2, 0);
    check("q_after_set", q_in, 4'b0100);
    do_cmd(OP_TOGGLE, 2, 1);
    check("q_after_toggle", q_in, 4'b0000);

    do_cmd(OP_SET, 0, 1);
    do_cmd(OP_SET, 1, 1);
    do_cmd(OP_SET, 3, 1);
    check("q_preload", q_in, 4'b1011);
    do_cmd(OP_CLEAR, 0, 1);
    check("q_after_clear", q_in, 4'b0000);

    stuck = 4'b0010;
    do_cmd(OP_SET, 1, 1);
    stuck = 4'b0000;
    do_cmd(OP_RESET, 1, 0);

    // Out-of-range index on a three-latch bank.
    check("n3_ready", ready3, 1);
    valid3 = 1'b1;
    op3 = OP_SET;
    idx3 = 2'd3;
    @(negedge clk);
    valid3 = 1'b0;
    check("badidx_done", done3, 1);
    check("badidx_err", err3, 1);
    check("badidx_s", s3, 0);
    check("badidx_r", r3, 0);
    check("badidx_ready_low", ready3, 0);
    @(negedge clk);
    check("badidx_done_clear", done3, 0);
    check("badidx_ready", ready3, 1);
    check("badidx_s2", s3, 0);
    check("badidx_r2", r3, 0);

    // Reset lands in the second pulse cycle.
    cmd_valid = 1'b1;
    cmd_op = OP_SET;
    cmd_idx = 2'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("midrst_pulse1", s_out, 4'b0001);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_latch[0] = 1'b1;
    check("midrst_s", s_out, 0);
    check("midrst_r", r_out, 0);
    check("midrst_done", done, 0);
    check("midrst_ready", cmd_ready, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("midrst_no_done", done, 0);
    end

    for (int n = 0; n < 24; n++) begin
      logic [1:0] op;
      int idx;
      op  = 2'($urandom_range(0, 3));
      idx = int'($urandom_range(0, N - 1));
      do_cmd(op, idx, n != 0);
      check("rand_q", q_in, model_latch);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
